// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IF/MEM memory arbiter.
package mem_arb_pkg;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
    typedef enum logic {OWN_I, OWN_D} owner_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// Single-ported memory request/grant/valid bus seen by the arbiter.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = mem_arb_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = mem_arb_pkg::DATA_WIDTH
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory between instruction fetch and data access, one transaction
// in flight; squashed fetches run to completion and are silently dropped.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = mem_arb_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = mem_arb_pkg::DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_req_i,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    input  logic                  i_flush_i,
    output logic                  i_valid_o,
    output logic [DATA_WIDTH-1:0] i_rdata_o,
    output logic                  i_stall_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_valid_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  d_stall_o,
    mem_arbiter_if.master         mem
);
    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    owner_e                last_owner_q, last_owner_d;
    logic                  discard_q, discard_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  i_elig;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        discard_d    = discard_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_valid_o    = 1'b0;
        i_rdata_o    = '0;
        d_valid_o    = 1'b0;
        d_rdata_o    = '0;
        i_elig       = i_req_i && !i_flush_i;

        unique case (state_q)
            IDLE: begin
                // D has priority except directly after a D access with a live fetch waiting
                if (d_req_i && !(last_owner_q == OWN_D && i_elig)) begin
                    owner_d = OWN_D;
                    we_d    = d_we_i;
                    addr_d  = d_addr_i;
                    wdata_d = d_wdata_i;
                    state_d = REQ;
                end else if (i_elig) begin
                    owner_d = OWN_I;
                    we_d    = 1'b0;
                    addr_d  = i_addr_i;
                    wdata_d = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (owner_q == OWN_I && i_flush_i) discard_d = 1'b1;
                if (mem.mem_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (owner_q == OWN_I && i_flush_i) discard_d = 1'b1;
                if (mem.mem_rvalid) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                    discard_d    = 1'b0;
                    if (owner_q == OWN_D) begin
                        d_valid_o = 1'b1;
                        d_rdata_o = mem.mem_rdata;
                    end else if (!discard_q && !i_flush_i) begin
                        i_valid_o = 1'b1;
                        i_rdata_o = mem.mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_I;
            discard_q    <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            discard_q    <= discard_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign mem.mem_req   = (state_q == REQ);
    assign mem.mem_we    = (state_q == REQ) && we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign i_stall_o = i_req_i && !i_valid_o;
    assign d_stall_o = d_req_i && !d_valid_o;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory and per-requester
// scoreboards of expected read data.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, i_flush, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_valid, i_stall, d_valid, d_stall;
    logic [31:0] i_rdata, d_rdata;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mif ();

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .i_req_i  (i_req),
        .i_addr_i (i_addr),
        .i_flush_i(i_flush),
        .i_valid_o(i_valid),
        .i_rdata_o(i_rdata),
        .i_stall_o(i_stall),
        .d_req_i  (d_req),
        .d_we_i   (d_we),
        .d_addr_i (d_addr),
        .d_wdata_i(d_wdata),
        .d_valid_o(d_valid),
        .d_rdata_o(d_rdata),
        .d_stall_o(d_stall),
        .mem      (mif)
    );

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    logic [31:0] iq[$];
    logic [31:0] dq[$];

    // ---------------- memory model ----------------
    int          gnt_wait = 0;
    int          rv_lat   = 1;
    bit          stray    = 1'b0;
    int          wait_cnt;
    int          lat_cnt;
    bit          pend;
    logic [31:0] p_addr;
    logic        p_we;
    logic [31:0] wr_val [256];
    bit          wr_ok  [256];

    function automatic logic [31:0] pat(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2408_0005;
        return {a[15:0] ^ 16'h5A5A, a[31:16]};
    endfunction

    function automatic logic [31:0] mrd(input logic [31:0] a, input logic we);
        if (we) return 32'h0;
        if (wr_ok[a[9:2]]) return wr_val[a[9:2]];
        return pat(a);
    endfunction

    always_comb mif.mem_gnt = mif.mem_req && (wait_cnt >= gnt_wait);

    always @(posedge clk) begin
        if (!rst_n) begin
            pend           <= 1'b0;
            wait_cnt       <= 0;
            lat_cnt        <= 0;
            mif.mem_rvalid <= 1'b0;
            mif.mem_rdata  <= '0;
        end else begin
            mif.mem_rvalid <= 1'b0;
            mif.mem_rdata  <= '0;
            if (pend) begin
                if (lat_cnt <= 1) begin
                    mif.mem_rvalid <= 1'b1;
                    mif.mem_rdata  <= mrd(p_addr, p_we);
                    pend           <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt - 1;
                end
            end
            if (mif.mem_req && !mif.mem_gnt) wait_cnt <= wait_cnt + 1;
            if (mif.mem_req && mif.mem_gnt) begin
                wait_cnt <= 0;
                if (mif.mem_we) begin
                    wr_val[mif.mem_addr[9:2]] <= mif.mem_wdata;
                    wr_ok[mif.mem_addr[9:2]]  <= 1'b1;
                end
                if (rv_lat <= 1) begin
                    mif.mem_rvalid <= 1'b1;
                    mif.mem_rdata  <= mrd(mif.mem_addr, mif.mem_we);
                end else begin
                    pend    <= 1'b1;
                    lat_cnt <= rv_lat - 1;
                    p_addr  <= mif.mem_addr;
                    p_we    <= mif.mem_we;
                end
            end
            if (stray) mif.mem_rvalid <= 1'b1;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (i_valid === 1'b1) begin
                if (iq.size() == 0) chk("i_valid_unexpected", 32'(i_valid), 32'h0);
                else chk("i_rdata", i_rdata, iq.pop_front());
            end
            if (d_valid === 1'b1) begin
                if (dq.size() == 0) chk("d_valid_unexpected", 32'(d_valid), 32'h0);
                else chk("d_rdata", d_rdata, dq.pop_front());
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return i_valid;
            1:       return d_valid;
            2:       return mif.mem_req;
            default: return mif.mem_rvalid;
        endcase
    endfunction

    task automatic wait_sig(input int w, input string tag);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (sig(w) === 1'b1) return;
        end
        chk({tag, "_timeout"}, 32'(sig(w)), 32'h1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; i_req = 1'b0; i_flush = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        nxt();
        nxt();
        @(negedge clk);
        chk("rst_mem_req", 32'(mif.mem_req), 32'h0);
        chk("rst_mem_we", 32'(mif.mem_we), 32'h0);
        chk("rst_mem_addr", mif.mem_addr, 32'h0);
        chk("rst_i_valid", 32'(i_valid), 32'h0);
        chk("rst_d_valid", 32'(d_valid), 32'h0);
        chk("rst_i_stall", 32'(i_stall), 32'h0);
        nxt();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // lone fetch
        do_reset();
        i_req = 1'b1; i_addr = 32'h0040_0000; iq.push_back(32'h2408_0005);
        @(negedge clk);
        chk("lf_c0_stall", 32'(i_stall), 32'h1);
        chk("lf_c0_req", 32'(mif.mem_req), 32'h0);
        @(negedge clk);
        chk("lf_c1_req", 32'(mif.mem_req), 32'h1);
        chk("lf_c1_addr", mif.mem_addr, 32'h0040_0000);
        chk("lf_c1_stall", 32'(i_stall), 32'h1);
        @(negedge clk);
        chk("lf_c2_valid", 32'(i_valid), 32'h1);
        chk("lf_c2_data", i_rdata, 32'h2408_0005);
        chk("lf_c2_stall", 32'(i_stall), 32'h0);
        nxt();
        i_req = 1'b0;
        @(negedge clk);
        chk("lf_c3_valid", 32'(i_valid), 32'h0);
        chk("lf_c3_req", 32'(mif.mem_req), 32'h0);

        // conflict from reset: D first, then I despite D re-requesting
        do_reset();
        i_req = 1'b1; i_addr = 32'h0040_0004; iq.push_back(pat(32'h0040_0004));
        d_req = 1'b1; d_addr = 32'h1000_0010; dq.push_back(pat(32'h1000_0010));
        wait_sig(2, "c_req1");
        chk("c_first_addr", mif.mem_addr, 32'h1000_0010);
        chk("c_i_stall", 32'(i_stall), 32'h1);
        wait_sig(1, "c_dval1");
        chk("c_i_not_yet", 32'(i_valid), 32'h0);
        nxt();
        d_addr = 32'h1000_0014; dq.push_back(pat(32'h1000_0014));
        wait_sig(2, "c_req2");
        chk("c_i_next_addr", mif.mem_addr, 32'h0040_0004);
        chk("c_d_stall", 32'(d_stall), 32'h1);
        wait_sig(0, "c_ival");
        nxt();
        i_req = 1'b0;
        wait_sig(2, "c_req3");
        chk("c_d2_addr", mif.mem_addr, 32'h1000_0014);
        wait_sig(1, "c_dval2");
        nxt();
        d_req = 1'b0;

        // store held through three cycles without grant, then read back
        gnt_wait = 3;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000_0020; d_wdata = 32'hDEAD_BEEF;
        dq.push_back(32'h0);
        wait_sig(2, "s_req");
        for (int i = 0; i < 4; i++) begin
            chk("s_req_held", 32'(mif.mem_req), 32'h1);
            chk("s_we", 32'(mif.mem_we), 32'h1);
            chk("s_addr", mif.mem_addr, 32'h1000_0020);
            chk("s_wdata", mif.mem_wdata, 32'hDEAD_BEEF);
            if (i < 3) @(negedge clk);
        end
        wait_sig(1, "s_dval");
        chk("s_d_stall", 32'(d_stall), 32'h0);
        nxt();
        d_req = 1'b0; d_we = 1'b0; d_wdata = '0; gnt_wait = 0;
        d_req = 1'b1; d_addr = 32'h1000_0020; dq.push_back(32'hDEAD_BEEF);
        wait_sig(1, "s_rdback");
        nxt();
        d_req = 1'b0;

        // flush mid-fetch: squashed data dropped, redirected fetch delivered
        rv_lat = 3;
        i_req = 1'b1; i_addr = 32'h0040_0008;
        wait_sig(2, "f_req1");
        nxt();
        i_flush = 1'b1; i_addr = 32'h0040_0100; iq.push_back(pat(32'h0040_0100));
        @(negedge clk);
        chk("f_flush_nv", 32'(i_valid), 32'h0);
        nxt();
        i_flush = 1'b0;
        wait_sig(3, "f_rv1");
        chk("f_discard_nv", 32'(i_valid), 32'h0);
        chk("f_discard_stall", 32'(i_stall), 32'h1);
        wait_sig(2, "f_req2");
        chk("f_new_addr", mif.mem_addr, 32'h0040_0100);
        wait_sig(0, "f_ival");
        nxt();
        i_req = 1'b0; rv_lat = 1;

        // reset mid-WAIT, then a stray response
        rv_lat = 4;
        i_req = 1'b1; i_addr = 32'h0040_000C;
        wait_sig(2, "r_req");
        nxt();
        rst_n = 1'b0; i_req = 1'b0;
        nxt();
        rst_n = 1'b1;
        @(negedge clk);
        chk("r_mem_req", 32'(mif.mem_req), 32'h0);
        chk("r_mem_addr", mif.mem_addr, 32'h0);
        chk("r_i_valid", 32'(i_valid), 32'h0);
        chk("r_d_valid", 32'(d_valid), 32'h0);
        nxt();
        stray = 1'b1;
        nxt();
        stray = 1'b0;
        @(negedge clk);
        chk("r_stray_i", 32'(i_valid), 32'h0);
        chk("r_stray_d", 32'(d_valid), 32'h0);
        chk("r_stray_req", 32'(mif.mem_req), 32'h0);

        // back-to-back loads, 5-cycle latency
        rv_lat = 5;
        begin
            int nval;
            nval = 0;
            for (int k = 0; k < 4; k++) begin
                bit got;
                got = 1'b0;
                d_req = 1'b1; d_addr = 32'h1000_0100 + 32'(4 * k);
                dq.push_back(pat(32'h1000_0100 + 32'(4 * k)));
                for (int c = 0; c < 20 && !got; c++) begin
                    @(negedge clk);
                    if (d_valid === 1'b1) begin
                        got = 1'b1;
                        nval++;
                        chk("b_deliv_stall", 32'(d_stall), 32'h0);
                    end else begin
                        chk("b_stall", 32'(d_stall), 32'h1);
                    end
                end
                if (!got) chk("b_timeout", 32'(d_valid), 32'h1);
                nxt();
            end
            d_req = 1'b0;
            repeat (8) @(negedge clk);
            chk("b_count", 32'(nval), 32'd4);
        end

        chk("iq_drained", 32'(iq.size()), 32'h0);
        chk("dq_drained", 32'(dq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
